// File: rtl/onehot_pkg.sv
// onehot_pkg: shared widths and the index-to-one-hot helper for the demux writer and decoders.
package onehot_pkg;

    localparam int DEF_K = 5;
    localparam int DEF_N = 16;
    localparam int MAX_N = 32;

    function automatic logic [MAX_N-1:0] idx2onehot(input logic [5:0] idx, input int n);
        return (int'(idx) < n) ? MAX_N'(1) << idx : '0;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: binary index to N-bit one-hot select; all-zero when idx >= N.
module onehot_decoder
    import onehot_pkg::*;
#(
    parameter int  N  = DEF_N,
    localparam int IW = $clog2(N)
) (
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    assign onehot = N'(idx2onehot(6'(idx), N));

endmodule

// File: rtl/onehot_demux_writer.sv
// onehot_demux_writer: one-stage write demux into N holding registers exposed flat.
// Optional sticky per-destination written flags under WRITTEN_TRACK_EN.
module onehot_demux_writer
    import onehot_pkg::*;
#(
    parameter int  K  = DEF_K,
    parameter int  N  = DEF_N,
    localparam int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   in_data,
    input  logic [IW-1:0]  in_idx,
    input  logic           stall,
    input  logic           clr,
    output logic [N-1:0]   sel_onehot,
    output logic [N-1:0]   dest_we,
    output logic [N*K-1:0] regs_flat,
    output logic           err,
    output logic [N-1:0]   written
);

    logic                  stage_valid;
    logic [K-1:0]          stage_data;
    logic [IW-1:0]         stage_idx;
    logic [N-1:0]          dec;
    logic [N-1:0][K-1:0]   regs;
    logic                  accept;

    assign in_ready   = !stage_valid || !stall;
    assign accept     = in_valid && in_ready;
    assign sel_onehot = stage_valid ? dec : '0;
    assign dest_we    = stall ? '0 : sel_onehot;
    assign err        = stage_valid && !stall && (int'(stage_idx) >= N);
    assign regs_flat  = regs;

    onehot_decoder #(.N(N)) u_dec (
        .idx    (stage_idx),
        .onehot (dec)
    );

    // clr drops a stalled pending write as well as draining a normal one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
            stage_idx   <= '0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            stage_data  <= in_data;
            stage_idx   <= in_idx;
        end else if (!stall || clr) begin
            stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (clr) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (dest_we[i]) regs[i] <= stage_data;
        end
    end

`ifdef WRITTEN_TRACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) written <= '0;
        else if (clr) written <= '0;
        else written <= written | dest_we;
    end
`else
    assign written = '0;
`endif

endmodule

// File: tb/tb_onehot_demux_writer.sv
// tb_onehot_demux_writer: directed checks of onehot_demux_writer at N=16 and N=12.
module tb_onehot_demux_writer;

    localparam int K  = 5;
    localparam int N  = 16;
    localparam int N2 = 12;
`ifdef WRITTEN_TRACK_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, stall, clr, err;
    logic [K-1:0]  in_data;
    logic [3:0]    in_idx;
    logic [N-1:0]  sel_onehot, dest_we, written;
    logic [N*K-1:0] regs_flat;

    logic           in_valid2, in_ready2, err2;
    logic [K-1:0]   in_data2;
    logic [3:0]     in_idx2;
    logic [N2-1:0]  sel2, we2, written2;
    logic [N2*K-1:0] regs2;

    int tests = 0;
    int fails = 0;

    onehot_demux_writer #(.K(K), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_idx(in_idx), .stall(stall), .clr(clr),
        .sel_onehot(sel_onehot), .dest_we(dest_we), .regs_flat(regs_flat),
        .err(err), .written(written)
    );

    onehot_demux_writer #(.K(K), .N(N2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_idx(in_idx2), .stall(stall), .clr(clr),
        .sel_onehot(sel2), .dest_we(we2), .regs_flat(regs2),
        .err(err2), .written(written2)
    );

    function automatic logic [K-1:0] rg(input int i);
        return regs_flat[i*K +: K];
    endfunction

    function automatic logic [N-1:0] wexp(input logic [N-1:0] v);
        return WT ? v : '0;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 0; in_data = 0; in_idx = 0; stall = 0; clr = 0;
        in_valid2 = 0; in_data2 = 0; in_idx2 = 0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (regs_flat !== '0) begin fails++; $display("FAIL rst_regs got %h exp 0", regs_flat); end
        tests++; if (sel_onehot !== '0) begin fails++; $display("FAIL rst_sel got %h exp 0", sel_onehot); end
        tests++; if (dest_we !== '0 || err !== 1'b0) begin fails++; $display("FAIL rst_we_err got %h/%b exp 0/0", dest_we, err); end
        tests++; if (written !== '0) begin fails++; $display("FAIL rst_written got %h exp 0", written); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", in_ready); end
        in_valid = 1; in_idx = 5; in_data = 5'h09;
        @(negedge clk);
        in_valid = 0;
        #1;
        tests++; if (sel_onehot !== 16'h0020) begin fails++; $display("FAIL rst_pending_sel got %h exp 0020", sel_onehot); end
        rst_n = 1'b0;
        #1;
        tests++; if (sel_onehot !== '0) begin fails++; $display("FAIL rst_async_sel got %h exp 0", sel_onehot); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        tests++; if (regs_flat !== '0) begin fails++; $display("FAIL rst_mid_regs got %h exp 0", regs_flat); end
        tests++; if (in_ready !== 1'b1 || sel_onehot !== '0) begin fails++; $display("FAIL rst_mid_ready_sel got %b/%h exp 1/0", in_ready, sel_onehot); end
    endtask

    task automatic test_single;
        @(negedge clk);
        in_valid = 1; in_idx = 3; in_data = 5'h1A;
        @(negedge clk);
        in_valid = 0;
        #1;
        tests++; if (sel_onehot !== 16'h0008) begin fails++; $display("FAIL single_sel got %h exp 0008", sel_onehot); end
        tests++; if (dest_we !== 16'h0008) begin fails++; $display("FAIL single_we got %h exp 0008", dest_we); end
        tests++; if (rg(3) !== 5'h00) begin fails++; $display("FAIL single_early got %h exp 00", rg(3)); end
        @(negedge clk); #1;
        tests++; if (rg(3) !== 5'h1A) begin fails++; $display("FAIL single_reg got %h exp 1a", rg(3)); end
        tests++; if (sel_onehot !== '0) begin fails++; $display("FAIL single_idle got %h exp 0", sel_onehot); end
        tests++; if (written !== wexp(16'h0008)) begin fails++; $display("FAIL single_written got %h exp %h", written, wexp(16'h0008)); end
    endtask

    task automatic test_burst;
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            in_valid = 1; in_idx = 4'(i); in_data = 5'(i + 1);
            #1;
            if (i > 0) begin
                e = 16'h1 << (i - 1);
                tests++; if (sel_onehot !== e || !$onehot(sel_onehot) || in_ready !== 1'b1) begin
                    fails++; $display("FAIL burst_sel[%0d] got %h rdy %b exp %h rdy 1", i, sel_onehot, in_ready, e);
                end
            end
        end
        @(negedge clk);
        in_valid = 0;
        #1;
        tests++; if (sel_onehot !== 16'h8000) begin fails++; $display("FAIL burst_last_sel got %h exp 8000", sel_onehot); end
        @(negedge clk); #1;
        for (int i = 0; i < N; i++) begin
            tests++; if (rg(i) !== 5'(i + 1)) begin fails++; $display("FAIL burst_reg[%0d] got %h exp %h", i, rg(i), 5'(i + 1)); end
        end
        tests++; if (written !== wexp(16'hFFFF)) begin fails++; $display("FAIL burst_written got %h exp %h", written, wexp(16'hFFFF)); end
    endtask

    task automatic test_stall;
        @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        #1;
        tests++; if (regs_flat !== '0 || written !== '0) begin fails++; $display("FAIL clr_all got %h/%h exp 0/0", regs_flat, written); end
        in_valid = 1; in_idx = 7; in_data = 5'h11;
        @(negedge clk);
        in_valid = 0; stall = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (in_ready !== 1'b0 || dest_we !== '0 || sel_onehot !== 16'h0080) begin
                fails++; $display("FAIL stall_hold[%0d] got rdy %b we %h sel %h exp 0/0000/0080", c, in_ready, dest_we, sel_onehot);
            end
            tests++; if (rg(7) !== 5'h00 || written !== '0) begin fails++; $display("FAIL stall_reg[%0d] got %h/%h exp 00/0", c, rg(7), written); end
            @(negedge clk);
        end
        stall = 0;
        #1;
        tests++; if (dest_we !== 16'h0080 || rg(7) !== 5'h00) begin fails++; $display("FAIL stall_release got %h/%h exp 0080/00", dest_we, rg(7)); end
        @(negedge clk); #1;
        tests++; if (rg(7) !== 5'h11 || sel_onehot !== '0) begin fails++; $display("FAIL stall_write got %h/%h exp 11/0", rg(7), sel_onehot); end
        tests++; if (written !== wexp(16'h0080)) begin fails++; $display("FAIL stall_written got %h exp %h", written, wexp(16'h0080)); end
    endtask

    task automatic test_clr;
        @(negedge clk);
        in_valid = 1; in_idx = 9; in_data = 5'h0F;
        @(negedge clk);
        in_idx = 2; in_data = 5'h04;
        @(negedge clk);
        in_valid = 0; clr = 1;
        #1;
        tests++; if (dest_we !== 16'h0004 || rg(9) !== 5'h0F) begin fails++; $display("FAIL clr_pre got %h/%h exp 0004/0f", dest_we, rg(9)); end
        @(negedge clk);
        clr = 0;
        #1;
        tests++; if (rg(2) !== 5'h00 || rg(9) !== 5'h00 || rg(7) !== 5'h00) begin
            fails++; $display("FAIL clr_regs got %h/%h/%h exp 00/00/00", rg(2), rg(9), rg(7));
        end
        tests++; if (written !== '0 || sel_onehot !== '0) begin fails++; $display("FAIL clr_flags got %h/%h exp 0/0", written, sel_onehot); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_valid = 1; in_idx = 4; in_data = 5'h01;
        @(negedge clk);
        in_data = 5'h02;
        #1;
        tests++; if (sel_onehot !== 16'h0010 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_first got %h rdy %b exp 0010 rdy 1", sel_onehot, in_ready); end
        @(negedge clk);
        in_valid = 0;
        #1;
        tests++; if (rg(4) !== 5'h01 || sel_onehot !== 16'h0010) begin fails++; $display("FAIL b2b_mid got %h/%h exp 01/0010", rg(4), sel_onehot); end
        @(negedge clk); #1;
        tests++; if (rg(4) !== 5'h02 || sel_onehot !== '0) begin fails++; $display("FAIL b2b_last got %h/%h exp 02/0", rg(4), sel_onehot); end
    endtask

    task automatic test_n12;
        @(negedge clk);
        in_valid2 = 1; in_idx2 = 13; in_data2 = 5'h1F;
        @(negedge clk);
        in_idx2 = 11; in_data2 = 5'h03;
        #1;
        tests++; if (err2 !== 1'b1 || sel2 !== '0 || we2 !== '0) begin fails++; $display("FAIL n12_oob got err %b sel %h we %h exp 1/000/000", err2, sel2, we2); end
        @(negedge clk);
        in_valid2 = 0;
        #1;
        tests++; if (err2 !== 1'b0 || sel2 !== 12'h800) begin fails++; $display("FAIL n12_next got err %b sel %h exp 0/800", err2, sel2); end
        tests++; if (regs2 !== '0) begin fails++; $display("FAIL n12_noreg got %h exp 0", regs2); end
        @(negedge clk); #1;
        tests++; if (regs2 !== (60'h3 << 55) || err2 !== 1'b0) begin fails++; $display("FAIL n12_write got %h err %b exp %h err 0", regs2, err2, 60'h3 << 55); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_stall;
        test_clr;
        test_back_to_back;
        test_n12;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
